// File: rtl/fxp_pkg.sv
// Shared definitions for the S,10.21 fixed-point datapath (divider and multiplier).
package fxp_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 21;

    localparam logic [DEF_WIDTH-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [DEF_WIDTH-1:0] SAT_NEG = 32'h8000_0000;

    typedef logic signed [DEF_WIDTH-1:0] fxp_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift a dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // Compare the widened trial remainder; after a successful subtract the
    // remainder is below the divisor, so the low WIDTH bits hold it exactly.
    always_comb begin
        trial = {rem_in, bit_in};
        q_bit = (trial >= {1'b0, divisor});
        if (q_bit) begin
            rem_out = trial[WIDTH-1:0] - divisor;
        end else begin
            rem_out = trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: result = (a << FRAC) / b, one quotient
// bit per cycle, truncated toward zero, saturating on overflow and on b == 0.
module fixed_point_divider
    import fxp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW);

    localparam logic [WIDTH-1:0] SAT_P     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_N     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [QW-1:0]    Q_MAX_POS = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [QW-1:0]    Q_MAX_NEG = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_INIT  = CW'(QW - 1);

    div_state_t       state_reg, state_next;
    logic             sign_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] rem_reg, rem_next;
    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after QW steps this register holds the whole unsigned quotient.
    logic [QW-1:0]    dq_reg, dq_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             ovf_reg, dbz_reg;
    logic             q_bit;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] final_result;
    logic             final_ovf;

    // Magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (dq_reg[QW-1]),
        .divisor (divisor_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign dq_next = {dq_reg[QW-2:0], q_bit};

    // Apply sign and saturation to the quotient completed this cycle.
    always_comb begin
        final_ovf    = 1'b0;
        final_result = dq_next[WIDTH-1:0];
        if (!sign_reg) begin
            if (dq_next > Q_MAX_POS) begin
                final_ovf    = 1'b1;
                final_result = SAT_P;
            end
        end else begin
            if (dq_next > Q_MAX_NEG) begin
                final_ovf    = 1'b1;
                final_result = SAT_N;
            end else begin
                final_result = -dq_next[WIDTH-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg    <= 1'b0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            dq_reg      <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            ovf_reg     <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
                        divisor_reg <= abs_b;
                        dq_reg      <= {abs_a, {FRAC{1'b0}}};
                        rem_reg     <= '0;
                        cnt_reg     <= CNT_INIT;
                        if (b == '0) begin
                            result_reg <= a[WIDTH-1] ? SAT_N : SAT_P;
                            ovf_reg    <= 1'b0;
                            dbz_reg    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dq_reg  <= dq_next;
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == '0) begin
                        result_reg <= final_result;
                        ovf_reg    <= final_ovf;
                        dbz_reg    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result      = result_reg;
    assign overflow    = ovf_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed, randomized,
// backpressure and reset-abort scenarios against an arithmetic model.
module tb_fixed_point_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, overflow, div_by_zero;
    logic [31:0] result;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    fixed_point_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    // Reference: exact integer division of magnitudes, then sign and clamp.
    function automatic void model(input logic [31:0] ta, input logic [31:0] tb,
                                  output logic [31:0] r, output logic o, output logic z);
        longint unsigned ma, mb, q;
        logic [31:0]     ql;
        o = 1'b0;
        z = 1'b0;
        if (tb == 32'd0) begin
            z = 1'b1;
            r = ta[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return;
        end
        ma = ta[31] ? (64'h1_0000_0000 - {32'd0, ta}) : {32'd0, ta};
        mb = tb[31] ? (64'h1_0000_0000 - {32'd0, tb}) : {32'd0, tb};
        q  = (ma << 21) / mb;
        ql = q[31:0];
        if (ta[31] == tb[31]) begin
            if (q > 64'h7FFF_FFFF) begin
                o = 1'b1;
                r = 32'h7FFF_FFFF;
            end else begin
                r = ql;
            end
        end else begin
            if (q > 64'h8000_0000) begin
                o = 1'b1;
                r = 32'h8000_0000;
            end else begin
                r = 32'd0 - ql;
            end
        end
    endfunction

    // Run one operation with out_ready high; lat counts edges from the accept
    // edge (inclusive) to the edge after which out_valid is seen high.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb,
                         output logic [31:0] r, output logic o, output logic z,
                         output int lat, output logic rdy);
        @(negedge clk);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        rdy = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        o = overflow;
        z = div_by_zero;
        $display("op a=%h b=%h -> result=%h ovf=%b dbz=%b lat=%0d", ta, tb, r, o, z, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (result !== 32'd0) $display("FAIL reset_result: got %h want 00000000", result); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0 || div_by_zero !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", overflow, div_by_zero); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    logic [31:0] dir_a   [15] = '{32'h0060_0000, 32'hFFE0_0000, 32'h0020_0000, 32'hFFE0_0000,
                                  32'h7D00_0000, 32'h8300_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h0020_0000, 32'hFFE0_0000, 32'h0000_0000};
    logic [31:0] dir_b   [15] = '{32'h0040_0000, 32'h0080_0000, 32'h0060_0000, 32'h0060_0000,
                                  32'h0000_0001, 32'h0000_0001, 32'hFFE0_0000, 32'h0020_0000,
                                  32'h0040_0000, 32'hFFC0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] dir_r   [15] = '{32'h0030_0000, 32'hFFF8_0000, 32'h000A_AAAA, 32'hFFF5_5556,
                                  32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                                  32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic        dir_o   [15] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic        dir_z   [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    task automatic test_directed();
        logic [31:0] r;
        logic        o, z, rdy;
        int          lat, exp_lat;
        for (int i = 0; i < 15; i++) begin
            do_op(dir_a[i], dir_b[i], r, o, z, lat, rdy);
            exp_lat = dir_z[i] ? 1 : 54;
            chk_cnt++; if (r !== dir_r[i]) $display("FAIL dir%0d_result: got %h want %h", i, r, dir_r[i]); else pass_cnt++;
            chk_cnt++; if (o !== dir_o[i]) $display("FAIL dir%0d_overflow: got %b want %b", i, o, dir_o[i]); else pass_cnt++;
            chk_cnt++; if (z !== dir_z[i]) $display("FAIL dir%0d_div_by_zero: got %b want %b", i, z, dir_z[i]); else pass_cnt++;
            chk_cnt++; if (lat != exp_lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] ta, tb, r, er;
        logic        o, z, eo, ez, rdy;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            ta = 32'($urandom) >> $urandom_range(0, 31);
            tb = 32'($urandom) >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ta = 32'd0 - ta;
            if ($urandom_range(0, 1) == 1) tb = 32'd0 - tb;
            model(ta, tb, er, eo, ez);
            do_op(ta, tb, r, o, z, lat, rdy);
            chk_cnt++; if (r !== er || o !== eo || z !== ez)
                $display("FAIL rand%0d: got %h/%b/%b want %h/%b/%b", i, r, o, z, er, eo, ez);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, held_r;
        logic        o, z, rdy, held_o, held_z;
        int          lat;
        out_ready = 1'b0;
        @(negedge clk);
        a = 32'h0060_0000;
        b = 32'h0040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk_cnt++; if (lat != 54) $display("FAIL bp_latency: got %0d want 54", lat); else pass_cnt++;
        held_r = result;
        held_o = overflow;
        held_z = div_by_zero;
        chk_cnt++; if (held_r !== 32'h0030_0000) $display("FAIL bp_result: got %h want 00300000", held_r); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp%0d_out_valid: got %b want 1", i, out_valid); else pass_cnt++;
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp%0d_in_ready: got %b want 0", i, in_ready); else pass_cnt++;
            chk_cnt++; if (result !== held_r || overflow !== held_o || div_by_zero !== held_z)
                $display("FAIL bp%0d_stable: got %h/%b/%b want %h/%b/%b", i, result, overflow, div_by_zero, held_r, held_o, held_z);
            else pass_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        $display("op a=00600000 b=00400000 -> result=%h ovf=%b dbz=%b held 10 cycles", held_r, held_o, held_z);
        @(posedge clk);
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", in_ready); else pass_cnt++;
        do_op(32'h0020_0000, 32'h0060_0000, r, o, z, lat, rdy);
        chk_cnt++; if (r !== 32'h000A_AAAA || o !== 1'b0 || z !== 1'b0)
            $display("FAIL bp_next_op: got %h/%b/%b want 000aaaaa/0/0", r, o, z);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] r;
        logic        o, z, rdy, seen_valid;
        int          lat;
        @(negedge clk);
        a = 32'h7D00_0000;
        b = 32'h0000_0003;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (result !== 32'd0 || overflow !== 1'b0 || div_by_zero !== 1'b0)
            $display("FAIL rst_mid_outputs: got %h/%b/%b want 00000000/0/0", result, overflow, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else pass_cnt++;
        seen_valid = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL rst_mid_stale: got %b want 0", seen_valid); else pass_cnt++;
        do_op(32'h0060_0000, 32'h0040_0000, r, o, z, lat, rdy);
        chk_cnt++; if (r !== 32'h0030_0000 || o !== 1'b0 || z !== 1'b0)
            $display("FAIL rst_mid_next_op: got %h/%b/%b want 00300000/0/0", r, o, z);
        else pass_cnt++;
        chk_cnt++; if (lat != 54) $display("FAIL rst_mid_latency: got %0d want 54", lat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta, tb, r, er;
        logic        o, z, eo, ez, rdy;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            ta = 32'($urandom) >> 8;
            tb = (i == 3) ? 32'd0 : (32'($urandom) >> 10);
            if (i % 2 == 1) ta = 32'd0 - ta;
            model(ta, tb, er, eo, ez);
            do_op(ta, tb, r, o, z, lat, rdy);
            chk_cnt++; if (rdy !== 1'b1) $display("FAIL b2b%0d_in_ready: got %b want 1", i, rdy); else pass_cnt++;
            chk_cnt++; if (r !== er || o !== eo || z !== ez)
                $display("FAIL b2b%0d: got %h/%b/%b want %h/%b/%b", i, r, o, z, er, eo, ez);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
